// File: rtl/spio_sched.sv
// spio_sched: Wishbone-controlled LED / push-button sequencer.
//
// The buttons are synchronized and debounced. A press (stable 0->1) latches
// an event flag, and enabled flags drive a level interrupt. Each LED can be
// off, on, blinking at a programmable rate, or a copy of an external status
// bit.
//
// Build option:
//   SPIO_DEBOUNCE_EN  defined   : per-button debounce counters are present
//                     undefined : stable state is the synchronizer output
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_wb_cyc/stb/we/addr      Wishbone classic-pipelined request (cyc ignored)
//   i_wb_data, i_wb_sel       write data, byte enables
//   o_wb_stall                always 0
//   o_wb_ack, o_wb_data       registered ack / read data, one cycle after stb
//   i_btn                     raw button pins, 1 = pressed
//   i_led                     external status bit for pass-through mode
//   o_led                     LED drive, 1 = lit
//   o_int                     registered level interrupt
//
// Register map:
//   addr 0 CTRL   : [3:0] stable, [7:4] events (W1C, sel[0]),
//                   [11:8] enables (sel[1]), [15:12] o_led
//   addr 1 LEDCFG : byte k = LED k {mode[7:6], HP[5:0]}
//                   mode 00 off, 01 on, 10 blink, 11 pass-through

module spio_sched #(
    parameter int NLED     = 2,
    parameter int NBTN     = 2,
    parameter int CLK_DIV  = 50000,
    parameter int DEBOUNCE = 250000
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic            i_wb_addr,
    input  logic [31:0]     i_wb_data,
    input  logic [3:0]      i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [31:0]     o_wb_data,
    input  logic [NBTN-1:0] i_btn,
    input  logic            i_led,
    output logic [NLED-1:0] o_led,
    output logic            o_int
);

    localparam int PW = $clog2(CLK_DIV);

    logic            w_unused;
    logic            w_wr_ctrl;
    logic            w_wr_led;
    logic            w_tick;

    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] w_stable;
    logic [NBTN-1:0] r_stable_d;
    logic [NBTN-1:0] w_set;
    logic [NBTN-1:0] w_clr;
    logic [NBTN-1:0] r_event;
    logic [NBTN-1:0] r_en;
    logic            r_int;

    logic [PW-1:0]   r_presc;

    logic [7:0]      r_cfg       [NLED];
    logic [5:0]      r_bcnt      [NLED];
    logic [7:0]      w_cfg_nxt   [NLED];
    logic [5:0]      w_bcnt_nxt  [NLED];
    logic [NLED-1:0] r_phase;
    logic [NLED-1:0] w_phase_nxt;
    logic [NLED-1:0] r_led;
    logic [NLED-1:0] w_led_nxt;

    logic            r_ack;
    logic [31:0]     r_rdata;
    logic [31:0]     w_ctrl_rd;
    logic [31:0]     w_led_rd;

    // Cycle is not qualified, upper data bytes and sel lanes beyond NLED have
    // no destination.
    assign w_unused = &{1'b0, i_wb_cyc, i_wb_data, i_wb_sel, (DEBOUNCE != 0)};

    assign w_wr_ctrl = i_wb_stb & i_wb_we & ~i_wb_addr;
    assign w_wr_led  = i_wb_stb & i_wb_we &  i_wb_addr;

    // ------------------------------------------------------------ buttons
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SPIO_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE);

    logic [NBTN-1:0] r_stable;
    logic [DW-1:0]   r_db_cnt [NBTN];

    // The counter only runs while the synchronized pin disagrees with the
    // stable value, so any agreement restarts the qualification window.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stable <= '0;
            for (int k = 0; k < NBTN; k++) r_db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NBTN; k++) begin
                if (r_sync2[k] == r_stable[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DW'(DEBOUNCE - 1)) begin
                    r_stable[k] <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = r_sync2;
`endif

    // ------------------------------------------------------------ events
    assign w_set = w_stable & ~r_stable_d;
    assign w_clr = (w_wr_ctrl && i_wb_sel[0]) ? i_wb_data[4 +: NBTN] : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stable_d <= '0;
            r_event    <= '0;
            r_en       <= '0;
            r_int      <= 1'b0;
        end else begin
            r_stable_d <= w_stable;
            // Set is applied after clear so a coincident press wins.
            r_event    <= (r_event & ~w_clr) | w_set;
            if (w_wr_ctrl && i_wb_sel[1]) r_en <= i_wb_data[8 +: NBTN];
            r_int      <= |(r_event & r_en);
        end
    end

    // ------------------------------------------------------------ tick
    assign w_tick = (r_presc == PW'(CLK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)  r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // ------------------------------------------------------------ LEDs
    // The drive value is derived from the post-edge config and phase, so a
    // mode write is visible on o_led at the write edge itself.
    always_comb begin
        w_phase_nxt = r_phase;
        w_led_nxt   = '0;
        for (int k = 0; k < NLED; k++) begin
            w_cfg_nxt[k]  = r_cfg[k];
            w_bcnt_nxt[k] = r_bcnt[k];
            if (w_wr_led && i_wb_sel[k]) begin
                w_cfg_nxt[k]   = i_wb_data[8*k +: 8];
                w_bcnt_nxt[k]  = '0;
                w_phase_nxt[k] = 1'b0;
            end else if (r_cfg[k][7:6] == 2'b10) begin
                if (w_tick) begin
                    if (r_bcnt[k] == r_cfg[k][5:0]) begin
                        w_bcnt_nxt[k]  = '0;
                        w_phase_nxt[k] = ~r_phase[k];
                    end else begin
                        w_bcnt_nxt[k]  = r_bcnt[k] + 6'd1;
                    end
                end
            end else begin
                w_bcnt_nxt[k] = '0;
            end
            case (w_cfg_nxt[k][7:6])
                2'b00:   w_led_nxt[k] = 1'b0;
                2'b01:   w_led_nxt[k] = 1'b1;
                2'b10:   w_led_nxt[k] = w_phase_nxt[k];
                default: w_led_nxt[k] = i_led;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NLED; k++) begin
                r_cfg[k]  <= '0;
                r_bcnt[k] <= '0;
            end
            r_phase <= '0;
            r_led   <= '0;
        end else begin
            for (int k = 0; k < NLED; k++) begin
                r_cfg[k]  <= w_cfg_nxt[k];
                r_bcnt[k] <= w_bcnt_nxt[k];
            end
            r_phase <= w_phase_nxt;
            r_led   <= w_led_nxt;
        end
    end

    // ------------------------------------------------------------ bus
    always_comb begin
        w_ctrl_rd               = '0;
        w_ctrl_rd[0 +: NBTN]    = w_stable;
        w_ctrl_rd[4 +: NBTN]    = r_event;
        w_ctrl_rd[8 +: NBTN]    = r_en;
        w_ctrl_rd[12 +: NLED]   = r_led;
        w_led_rd                = '0;
        for (int k = 0; k < NLED; k++) w_led_rd[8*k +: 8] = r_cfg[k];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= i_wb_stb;
            if (i_wb_stb) r_rdata <= i_wb_addr ? w_led_rd : w_ctrl_rd;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_led      = r_led;
    assign o_int      = r_int;

endmodule

// File: tb/tb_spio_sched.sv
module tb_spio_sched;

    localparam int NLED     = 2;
    localparam int NBTN     = 2;
    localparam int CLK_DIV  = 4;
    localparam int DEBOUNCE = 8;
`ifdef SPIO_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    // pin edge to stable update, in clock edges
    localparam int LAT = DB_EN ? 2 + DEBOUNCE : 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_cyc, wb_stb, wb_we, wb_addr;
    logic [31:0]     wb_data;
    logic [3:0]      wb_sel;
    logic            wb_stall, wb_ack;
    logic [31:0]     wb_rdata;
    logic [NBTN-1:0] btn;
    logic            led_in;
    logic [NLED-1:0] led;
    logic            irq;

    int n_vec = 0;
    int n_err = 0;

    spio_sched #(.NLED(NLED), .NBTN(NBTN), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
        .i_wb_data(wb_data), .i_wb_sel(wb_sel),
        .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_data(wb_rdata),
        .i_btn(btn), .i_led(led_in), .o_led(led), .o_int(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- reference model
    // Behavioural view: a pin value is seen two cycles late; it becomes stable
    // after DEBOUNCE consecutive disagreeing cycles; a blinking LED's phase is
    // the parity of (ticks since its config write) / (HP+1).
    bit [NBTN-1:0] m_p0, m_p1, m_stable, m_rose, m_event, m_en;
    int            m_run   [NBTN];
    bit            m_int, m_ack;
    logic [31:0]   m_rdata;
    int            m_presc;
    bit [7:0]      m_cfg   [NLED];
    int            m_ticks [NLED];
    bit [NLED-1:0] m_led;

    function automatic logic [31:0] m_ctrl_word();
        logic [31:0] w = '0;
        for (int b = 0; b < NBTN; b++) begin
            w[b]     = m_stable[b];
            w[4 + b] = m_event[b];
            w[8 + b] = m_en[b];
        end
        for (int k = 0; k < NLED; k++) w[12 + k] = m_led[k];
        return w;
    endfunction

    function automatic logic [31:0] m_led_word();
        logic [31:0] w = '0;
        for (int k = 0; k < NLED; k++) w = w | (32'(m_cfg[k]) << (8 * k));
        return w;
    endfunction

    task automatic model_reset();
        m_p0 = '0; m_p1 = '0; m_stable = '0; m_rose = '0; m_event = '0; m_en = '0;
        m_int = 0; m_ack = 0; m_rdata = '0; m_presc = 0; m_led = '0;
        for (int b = 0; b < NBTN; b++) m_run[b] = 0;
        for (int k = 0; k < NLED; k++) begin m_cfg[k] = '0; m_ticks[k] = 0; end
    endtask

    task automatic model_step();
        logic [31:0]   rd;
        bit            tick, wr_ctrl, wr_led;
        bit [NBTN-1:0] old_stable;
        int            hp;
        rd         = wb_addr ? m_led_word() : m_ctrl_word();
        tick       = (m_presc == CLK_DIV - 1);
        wr_ctrl    = wb_stb && wb_we && !wb_addr;
        wr_led     = wb_stb && wb_we && wb_addr;
        old_stable = m_stable;
        m_int      = |(m_event & m_en);
        for (int b = 0; b < NBTN; b++) begin
            if (wr_ctrl && wb_sel[0] && wb_data[4 + b]) m_event[b] = 0;
            if (m_rose[b]) m_event[b] = 1;
            if (wr_ctrl && wb_sel[1]) m_en[b] = wb_data[8 + b];
        end
        if (DB_EN) begin
            for (int b = 0; b < NBTN; b++) begin
                if (m_p1[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEBOUNCE) begin
                        m_stable[b] = m_p1[b];
                        m_run[b]    = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        m_p1 = m_p0;
        m_p0 = btn;
        if (!DB_EN) m_stable = m_p1;
        m_rose = m_stable & ~old_stable;
        for (int k = 0; k < NLED; k++) begin
            if (wr_led && wb_sel[k]) begin
                m_cfg[k]   = wb_data[8*k +: 8];
                m_ticks[k] = 0;
            end else if (tick) begin
                m_ticks[k]++;
            end
            hp = int'(m_cfg[k][5:0]);
            case (m_cfg[k][7:6])
                2'b00:   m_led[k] = 0;
                2'b01:   m_led[k] = 1;
                2'b10:   m_led[k] = ((m_ticks[k] / (hp + 1)) % 2) != 0;
                default: m_led[k] = led_in;
            endcase
        end
        m_presc = (m_presc + 1) % CLK_DIV;
        m_ack   = wb_stb;
        if (wb_stb) m_rdata = rd;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_led",   32'(led),    32'(m_led));
            chk("model_int",   32'(irq),    32'(m_int));
            chk("model_ack",   32'(wb_ack), 32'(m_ack));
            chk("stall",       32'(wb_stall), 32'd0);
            if (m_ack) chk("model_rdata", wb_rdata, m_rdata);
        end
    end

    // ---------------------------------------------------------- bus helpers
    task automatic bus(input bit we, input bit adr, input logic [31:0] d, input logic [3:0] sel);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = adr; wb_data = d; wb_sel = sel;
        @(negedge clk);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic rd_chk(input string name, input bit adr, input logic [31:0] exp);
        bus(1'b0, adr, 32'd0, 4'h0);
        chk(name, wb_rdata, exp);
    endtask

    typedef struct {
        bit          we;
        bit          adr;
        logic [31:0] d;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int n;
        tbl[0]  = '{0, 0, 32'h0,        4'h0, 32'h00000000};
        tbl[1]  = '{1, 1, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[2]  = '{0, 1, 32'h0,        4'h0, 32'h0000FFFF};
        tbl[3]  = '{1, 1, 32'h12345678, 4'h0, 32'h0};
        tbl[4]  = '{0, 1, 32'h0,        4'h0, 32'h0000FFFF};
        tbl[5]  = '{1, 1, 32'h0,        4'hF, 32'h0};
        tbl[6]  = '{1, 0, 32'h00000500, 4'h2, 32'h0};
        tbl[7]  = '{0, 0, 32'h0,        4'h0, 32'h00000100};
        tbl[8]  = '{1, 0, 32'h00000F00, 4'h1, 32'h0};
        tbl[9]  = '{0, 0, 32'h0,        4'h0, 32'h00000100};
        tbl[10] = '{1, 1, 32'h00004040, 4'h3, 32'h0};
        tbl[11] = '{0, 0, 32'h0,        4'h0, 32'h00003100};
        tbl[12] = '{1, 1, 32'h0,        4'h2, 32'h0};
        tbl[13] = '{0, 1, 32'h0,        4'h0, 32'h00000040};
        tbl[14] = '{0, 0, 32'h0,        4'h0, 32'h00001100};
        tbl[15] = '{1, 0, 32'h0,        4'h3, 32'h0};
        tbl[16] = '{1, 1, 32'h0,        4'hF, 32'h0};
        tbl[17] = '{0, 0, 32'h0,        4'h0, 32'h00000000};

        rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = 0;
        wb_data = '0; wb_sel = '0; btn = '0; led_in = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_led",  32'(led),    32'd0);
        chk("rst_int",  32'(irq),    32'd0);
        chk("rst_ack",  32'(wb_ack), 32'd0);
        chk("rst_data", wb_rdata,    32'd0);
        rst_n = 1;
        rd_chk("rst_ctrl", 1'b0, 32'h0);

        // register table
        foreach (tbl[i]) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].d, tbl[i].sel);
            chk("tbl_ack", 32'(wb_ack), 32'd1);
            if (!tbl[i].we) chk($sformatf("tbl_rd[%0d]", i), wb_rdata, tbl[i].exp);
        end

        // debounce and interrupt timing
        bus(1'b1, 1'b0, 32'h100, 4'h2);
        btn[0] = 1;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            chk($sformatf("irq_edge%0d", k), 32'(irq), (k == LAT + 2) ? 32'd1 : 32'd0);
        end
        rd_chk("press_ctrl", 1'b0, 32'h111);
        btn[1] = 1;
        repeat (5) @(negedge clk);
        btn[1] = 0;
        repeat (15) @(negedge clk);
        rd_chk("glitch_ctrl", 1'b0, DB_EN ? 32'h111 : 32'h131);

        // clear, then clear coinciding with a new press
        bus(1'b1, 1'b0, 32'h10, 4'h1);
        chk("clr_int_lag", 32'(irq), 32'd1);
        @(negedge clk);
        chk("clr_int_low", 32'(irq), 32'd0);
        rd_chk("clr_ctrl", 1'b0, DB_EN ? 32'h101 : 32'h121);
        btn[0] = 0;
        repeat (LAT + 4) @(negedge clk);
        btn[0] = 1;
        repeat (LAT) @(negedge clk);
        bus(1'b1, 1'b0, 32'h10, 4'h1);
        rd_chk("set_wins", 1'b0, DB_EN ? 32'h111 : 32'h131);

        // short pulse: an event only without debounce
        bus(1'b1, 1'b0, 32'hF0, 4'h1);
        btn[0] = 0;
        repeat (LAT + 4) @(negedge clk);
        bus(1'b1, 1'b0, 32'hF0, 4'h1);
        btn[0] = 1;
        repeat (3) @(negedge clk);
        btn[0] = 0;
        repeat (LAT + 6) @(negedge clk);
        rd_chk("pulse_ctrl", 1'b0, DB_EN ? 32'h100 : 32'h110);

        // blink, write aligned to a tick edge so the first rise is at +12
        for (int k = 0; k < 2 * CLK_DIV && m_presc != CLK_DIV - 1; k++) @(negedge clk);
        bus(1'b1, 1'b1, 32'h82, 4'h1);
        n = 0;
        while (!led[0] && n < 30) begin @(negedge clk); n++; end
        chk("blink_first_rise", n, 12);
        n = 0;
        while (led[0] && n < 30) begin @(negedge clk); n++; end
        chk("blink_high", n, 12);
        n = 0;
        while (!led[0] && n < 30) begin @(negedge clk); n++; end
        chk("blink_low", n, 12);

        // modes on LED1
        bus(1'b1, 1'b1, 32'h4000, 4'h2);
        chk("mode_on", 32'(led[1]), 32'd1);
        bus(1'b1, 1'b1, 32'hC000, 4'h2);
        chk("pass_init", 32'(led[1]), 32'd0);
        led_in = 1;
        #1 chk("pass_lag", 32'(led[1]), 32'd0);
        @(negedge clk);
        chk("pass_hi", 32'(led[1]), 32'd1);
        led_in = 0;
        @(negedge clk);
        chk("pass_lo", 32'(led[1]), 32'd0);
        bus(1'b1, 1'b1, 32'hFFFFFFFF, 4'h0);
        rd_chk("sel0_ledcfg", 1'b1, 32'h0000C082);

        // reset mid-blink
        led_in = 1;
        repeat (7) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_led",  32'(led),    32'd0);
        chk("mid_rst_int",  32'(irq),    32'd0);
        chk("mid_rst_ack",  32'(wb_ack), 32'd0);
        chk("mid_rst_data", wb_rdata,    32'd0);
        @(negedge clk);
        rst_n = 1;
        rd_chk("mid_rst_ctrl",   1'b0, 32'h0);
        rd_chk("mid_rst_ledcfg", 1'b1, 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NBTN; b++)
                if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
            led_in  = 1'($urandom_range(0, 1));
            wb_cyc  = 1'($urandom_range(0, 1));
            wb_stb  = ($urandom_range(0, 3) == 0);
            wb_we   = 1'($urandom_range(0, 1));
            wb_addr = 1'($urandom_range(0, 1));
            wb_sel  = 4'($urandom_range(0, 15));
            wb_data = $urandom;
            if (wb_addr) wb_data = wb_data & 32'hC3C3C3C3;
            @(negedge clk);
        end
        wb_stb = 0; wb_we = 0; wb_cyc = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spio_sched.md
# spio_sched

Wishbone-controlled sequencer for the board's user LEDs and push-buttons. Debounces the buttons, latches press events with a maskable interrupt, and drives each LED independently as off, on, a programmable blink, or a pass-through of an external status signal. It sits on the peripheral bus and owns the LED and button pins directly.

## Interface

- NLED, 2, number of LEDs, 1..4
- NBTN, 2, number of buttons, 1..4
- CLK_DIV, 50000, clock cycles per blink tick, ≥2
- DEBOUNCE, 250000, consecutive clock cycles a synchronized button must differ from its stable value before the stable value updates, ≥2
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone classic-pipelined strobes
- i_wb_addr  in  1  register select: 0 = CTRL, 1 = LEDCFG
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte enables
- o_wb_stall  out  1  tied 0
- o_wb_ack  out  1  registered ack
- o_wb_data  out  32  registered read data
- i_btn  in  NBTN  raw asynchronous button pins, 1 = pressed
- i_led  in  1  external status bit for pass-through mode
- o_led  out  NLED  LED drive, 1 = lit
- o_int  out  1  level interrupt, registered

## Operation

- **Reset values** (async assert on i_reset_n low): o_led=0, o_wb_ack=0, o_wb_data=0, o_int=0. Events, enables, LED configs, phases, blink counters, prescaler, debounce counters, synchronizers and stable states are all 0.
- **Bus**
  - o_wb_ack is asserted exactly one cycle after any cycle with i_wb_stb=1; i_wb_cyc is ignored.
  - Reads return the register value sampled in the strobe cycle.
  - Writes take effect on the clock edge ending the strobe cycle.
  - Unused read bits return 0.
- **CTRL** (addr 0)
  - Read layout: [3:0] stable button state; [7:4] event flags; [11:8] event enables; [15:12] o_led. Each field is zero-extended to 4 bits.
  - Write, when i_wb_sel[0]=1: 1s in data[7:4] clear the corresponding event flags. Writing 0 has no effect.
  - Write, when i_wb_sel[1]=1: data[11:8] loads the enables.
- **LEDCFG** (addr 1)
  - Byte k configures LED k: [7:6] mode, [5:0] HP. The blink half-period is HP+1 ticks.
  - A write with i_wb_sel[k]=1 loads byte k and also zeroes LED k's blink counter and phase.
  - Bytes for k ≥ NLED read 0 and ignore writes.
- **Buttons**
  - Each button passes through a 2-FF synchronizer, then a debounce counter.
  - The counter is cleared whenever sync == stable.
  - When sync ≠ stable, the counter increments; on reaching DEBOUNCE-1, stable takes the sync value and the counter clears.
- **Events**
  - A stable 0→1 transition on button k sets event[k].
  - If a set and a bus clear hit the same flag in the same cycle, set wins.
  - o_int <= |(event & enable).
- **Tick**
  - The prescaler counts 0..CLK_DIV-1 and wraps.
  - tick=1 in the cycle the prescaler equals CLK_DIV-1.
- **LED modes** (o_led[k] is registered)
  - 00 off: o_led=0, counter held at 0.
  - 01 on: o_led=1, counter held at 0.
  - 10 blink: on each tick, if counter==HP, clear the counter and toggle phase; otherwise increment. o_led=phase.
  - 11 pass-through: o_led=i_led, delayed one cycle.

## Timing

- Bus: read or write latency is 1 cycle. Back-to-back strobes get back-to-back acks. Never stalls.
- Button press to stable update: 2 (sync) + DEBOUNCE cycles after the pin edge, assuming the pin is held steady.
- Event flag is set 1 cycle after the stable state rises. o_int asserts 1 cycle after the event flag, if enabled.
- Clearing a flag via the bus: flag drops on the write edge; o_int drops 1 cycle later.
- Blink: after a config write, the first toggle occurs on tick number HP+1. The period is 2·(HP+1)·CLK_DIV cycles. HP=0 toggles on every tick.
- Pin bounces shorter than DEBOUNCE cycles produce no stable change and no event.
- Reset asserted mid-blink or mid-debounce returns all state to reset values immediately. Operation resumes from the first clock after deassertion.

## Configuration

- SPIO_DEBOUNCE_EN defined: debounce counters are present, as described above.
- SPIO_DEBOUNCE_EN undefined: no debounce counters; stable state = synchronizer output. Press-to-stable latency becomes 2 cycles, and DEBOUNCE is unused.
- Register map, events and interrupt are identical in both builds.

## Test plan

All scenarios use CLK_DIV=4, DEBOUNCE=8.

- **Reset:** hold reset, then release. Require o_led=0, o_int=0, o_wb_ack=0, and CTRL read = 0x00000000.
- **Debounce and IRQ:** write CTRL=0x100 with sel=4'h2. Raise i_btn[0] and hold for 10 cycles. Require:
  - CTRL[0]=1 after 2+8 cycles;
  - event[0] one cycle later;
  - o_int one cycle after that.
  - Then a 5-cycle glitch on i_btn[1] produces no event.
- **Clear versus set:** write CTRL data=0x10 with sel=4'h1. Require event[0]=0 and o_int low 1 cycle later. Then make the clear coincide with a new press edge: the flag stays 1.
- **Blink:** write LEDCFG=0x00000082 with sel=4'h1. Require o_led[0] to toggle every 3 ticks (12 cycles); the first rise is 12 cycles after the write.
- **Modes:** LEDCFG byte1=0x40 gives o_led[1]=1. Byte1=0xC0 makes o_led[1] follow i_led with a 1-cycle lag. Writes with sel=4'h0 change nothing.
- **Build without SPIO_DEBOUNCE_EN:** a 3-cycle pulse on i_btn[0] sets event[0].
